// File: rtl/game_day_pipe_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg: shared types and helpers for the game_day_pipe pipeline.
//   game_state_t : PLAY / OVER game state.
//   BONUS_SHIFT  : left shift applied to chained bonus and luck.
//   BONUS_W      : width of a stage bonus.
//   sat_add      : score + (bonus<<2) + (luck<<2), clipped to smax.
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } game_state_t;

  localparam int BONUS_SHIFT = 2;
  localparam int BONUS_W     = 2;

  // Sum is formed at 32 bits so it can never wrap before the clip.
  function automatic logic [31:0] sat_add(
    input logic [31:0]        score,
    input logic [BONUS_W-1:0] bonus,
    input logic [1:0]         luck,
    input logic [31:0]        smax
  );
    logic [31:0] sum;
    sum = score + (32'(bonus) << BONUS_SHIFT) + (32'(luck) << BONUS_SHIFT);
    if (sum > smax) begin
      return smax;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/game_day_pipe_stage.sv
// ---------------------------------------------------------------------------
// game_stage: one challenge of a day plus its pipeline register.
//   clk, rst_n, srst, en      : clock, async reset, flush, global shift enable
//   prev_valid/pass/bonus/fail: state of the day arriving from upstream
//   day_score/hard/luck       : this stage's fields, taken at accept time
//   stage_valid/pass/bonus/fail : registered result handed downstream
// The stage's own fields are delayed STAGE_IDX shifts internally so they
// line up with the day when it reaches this stage.
// ---------------------------------------------------------------------------
module game_stage
  import game_pkg::*;
#(
  parameter int SCORE_W   = 7,
  parameter int FS_W      = 2,
  parameter int STAGE_IDX = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               srst,
  input  logic               en,
  input  logic               prev_valid,
  input  logic               prev_pass,
  input  logic [BONUS_W-1:0] prev_bonus,
  input  logic [FS_W-1:0]    prev_fail,
  input  logic [SCORE_W-1:0] day_score,
  input  logic [SCORE_W-1:0] day_hard,
  input  logic [1:0]         day_luck,
  output logic               stage_valid,
  output logic               stage_pass,
  output logic [BONUS_W-1:0] stage_bonus,
  output logic [FS_W-1:0]    stage_fail
);

  localparam int          FW   = 2 * SCORE_W + 2;
  localparam logic [31:0] SMAX = (32'd1 << SCORE_W) - 32'd1;

  logic [FW-1:0]      day_fields_s;
  logic [FW-1:0]      cur_fields_s;
  logic [SCORE_W-1:0] total_s;
  logic               pass_s;
  logic [BONUS_W-1:0] bonus_s;
  logic [FS_W-1:0]    fail_s;

  assign day_fields_s = {day_score, day_hard, day_luck};

  if (STAGE_IDX == 0) begin : g_direct
    assign cur_fields_s = day_fields_s;
  end else begin : g_delay
    logic [STAGE_IDX-1:0][FW-1:0] dly_r;

    // Field delay line, shifted with the same enable as the day pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dly_r <= '0;
      end else if (en) begin
        dly_r[0] <= day_fields_s;
        for (int i = 1; i < STAGE_IDX; i++) begin
          dly_r[i] <= dly_r[i-1];
        end
      end
    end

    assign cur_fields_s = dly_r[STAGE_IDX-1];
  end

  // Score this stage; first failing stage records its index, later ones pass it on.
  always_comb begin
    total_s = SCORE_W'(sat_add(32'(cur_fields_s[FW-1 -: SCORE_W]), prev_bonus,
                               cur_fields_s[1:0], SMAX));
    pass_s  = prev_pass && (total_s > cur_fields_s[SCORE_W+1:2]);
    if (pass_s) begin
      bonus_s = total_s[SCORE_W-1 -: BONUS_W];
    end else begin
      bonus_s = {BONUS_W{1'b0}};
    end
    if (prev_pass && !pass_s) begin
      fail_s = FS_W'(STAGE_IDX);
    end else begin
      fail_s = prev_fail;
    end
  end

  // Pipeline register; flush only drops the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_pass  <= 1'b0;
      stage_bonus <= {BONUS_W{1'b0}};
      stage_fail  <= {FS_W{1'b0}};
    end else if (srst) begin
      stage_valid <= 1'b0;
    end else if (en) begin
      stage_valid <= prev_valid;
      stage_pass  <= pass_s;
      stage_bonus <= bonus_s;
      stage_fail  <= fail_s;
    end
  end

endmodule

// File: rtl/game_day_pipe.sv
// ---------------------------------------------------------------------------
// game_day_pipe: pipelined day evaluator with streak / lives / game-over.
//   clk, rst_n, restart       : clock, async active-low reset, new game
//   in_valid/in_ready         : day handshake; in_score/in_hard/in_luck fields
//   out_valid/out_ready       : retired day handshake
//   out_pass/out_bonus/out_fail_stage : result of the retired day
//   streak, lives, game_over  : game status
// ---------------------------------------------------------------------------
module game_day_pipe
  import game_pkg::*;
#(
  parameter  int NUM_STAGES = 3,
  parameter  int SCORE_W    = 7,
  parameter  int MAX_LIVES  = 3,
  parameter  int LIFE_W     = 2,
  parameter  int STREAK_W   = 4,
  localparam int FS_W       = $clog2(NUM_STAGES + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          restart,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_STAGES*SCORE_W-1:0] in_score,
  input  logic [NUM_STAGES*SCORE_W-1:0] in_hard,
  input  logic [NUM_STAGES*2-1:0]       in_luck,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_pass,
  output logic [1:0]                    out_bonus,
  output logic [FS_W-1:0]               out_fail_stage,
  output logic [STREAK_W-1:0]           streak,
  output logic [LIFE_W-1:0]             lives,
  output logic                          game_over
);

  logic [NUM_STAGES:0]                v_s;
  logic [NUM_STAGES:0]                pass_s;
  logic [NUM_STAGES:0][BONUS_W-1:0]   bonus_s;
  logic [NUM_STAGES:0][FS_W-1:0]      fail_s;
  game_state_t                        state_r;
  logic [BONUS_W-1:0]                 carry_r;
  logic [LIFE_W-1:0]                  lives_r;
  logic [STREAK_W-1:0]                streak_r;
  logic                               en_s;
  logic                               retire_s;

  // Whole pipeline stalls only when a finished day is waiting on the consumer.
  assign en_s     = ~v_s[NUM_STAGES] | out_ready;
  assign retire_s = v_s[NUM_STAGES] & out_ready;
  assign in_ready = en_s && (state_r == PLAY) && !restart;

  // Stage-0 seed: a new day starts passing, with the carry as bonus.
  assign v_s[0]     = in_valid & in_ready;
  assign pass_s[0]  = 1'b1;
  assign bonus_s[0] = carry_r;
  assign fail_s[0]  = FS_W'(NUM_STAGES);

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    game_stage #(
      .SCORE_W   (SCORE_W),
      .FS_W      (FS_W),
      .STAGE_IDX (k)
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .srst        (restart),
      .en          (en_s),
      .prev_valid  (v_s[k]),
      .prev_pass   (pass_s[k]),
      .prev_bonus  (bonus_s[k]),
      .prev_fail   (fail_s[k]),
      .day_score   (in_score[k*SCORE_W +: SCORE_W]),
      .day_hard    (in_hard[k*SCORE_W +: SCORE_W]),
      .day_luck    (in_luck[k*2 +: 2]),
      .stage_valid (v_s[k+1]),
      .stage_pass  (pass_s[k+1]),
      .stage_bonus (bonus_s[k+1]),
      .stage_fail  (fail_s[k+1])
    );
  end

  // Days draining after game over are reported as failed with no bonus.
  assign out_valid      = v_s[NUM_STAGES];
  assign out_pass       = pass_s[NUM_STAGES] && (state_r == PLAY);
  assign out_bonus      = (state_r == PLAY) ? bonus_s[NUM_STAGES] : {BONUS_W{1'b0}};
  assign out_fail_stage = fail_s[NUM_STAGES];
  assign streak         = streak_r;
  assign lives          = lives_r;
  assign game_over      = (state_r == OVER);

  // Game FSM and counters, updated on each retired day while playing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= PLAY;
      lives_r  <= LIFE_W'(MAX_LIVES);
      streak_r <= {STREAK_W{1'b0}};
      carry_r  <= {BONUS_W{1'b0}};
    end else if (restart) begin
      state_r  <= PLAY;
      lives_r  <= LIFE_W'(MAX_LIVES);
      streak_r <= {STREAK_W{1'b0}};
      carry_r  <= {BONUS_W{1'b0}};
    end else begin
      case (state_r)
        PLAY: begin
          if (retire_s) begin
            if (pass_s[NUM_STAGES]) begin
              if (streak_r != {STREAK_W{1'b1}}) begin
                streak_r <= streak_r + {{(STREAK_W-1){1'b0}}, 1'b1};
              end
              carry_r <= bonus_s[NUM_STAGES];
            end else begin
              streak_r <= {STREAK_W{1'b0}};
              carry_r  <= {BONUS_W{1'b0}};
              lives_r  <= lives_r - {{(LIFE_W-1){1'b0}}, 1'b1};
              if (lives_r == {{(LIFE_W-1){1'b0}}, 1'b1}) begin
                state_r <= OVER;
              end
            end
          end
        end
        OVER: begin
          state_r <= OVER;
        end
        default: begin
          state_r <= OVER;
        end
      endcase
    end
  end

endmodule
